// File: rtl/apb_mem_completer_if.sv
// APB bus bundle between the bridge requester port and the memory completer.
// The master modport is the requester side; the slave modport is the completer side.
interface apb_mem_completer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_mem_completer.sv
// APB completer that turns each APB transfer into one strobed memory access.
// Writes complete two cycles after the access phase starts, reads two cycles
// plus the memory read latency, and out-of-range or strobe-less writes complete
// one cycle after the access phase starts with PSLVERR and no memory access.
module apb_mem_completer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  apb_mem_completer_if.slave      apb,
  output logic                    mem_wr,
  output logic                    mem_rd,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic [DATA_WIDTH-1:0]   mem_data_out
);

  localparam int NB         = DATA_WIDTH / 8;
  localparam int LANE_SHIFT = (NB > 1) ? $clog2(NB) : 0;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                state_q;
  logic                  wr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  mem_wr_q;
  logic                  mem_rd_q;
  logic [NB-1:0]         mem_be_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_din_q;

  logic                  access_d;
  logic                  bad_d;
  logic [ADDR_WIDTH-1:0] word_addr_d;
  logic                  ack_d;

  // Only the access phase starts a transfer; a setup phase alone is ignored.
  assign access_d    = apb.psel & apb.penable;
  // Range check uses the full byte address; a write with no lanes is refused too.
  assign bad_d       = (apb.paddr >= ADDR_WIDTH'(MEM_BYTES)) ||
                       (apb.pwrite && (apb.pstrb == '0));
  // Sub-word address bits are dropped; lane selection comes from the strobes only.
  assign word_addr_d = apb.paddr >> LANE_SHIFT;

  // Completion is withheld from a requester that has already dropped psel.
  assign ack_d       = pready_q & apb.psel;
  assign apb.pready  = ack_d;
  assign apb.pslverr = ack_d & pslverr_q;
  assign apb.prdata  = ack_d ? prdata_q : '0;

  assign mem_wr      = mem_wr_q;
  assign mem_rd      = mem_rd_q;
  assign mem_be      = mem_be_q;
  assign mem_address = mem_addr_q;
  assign mem_data_in = mem_din_q;

  // Transfer sequencer: accept, issue one memory strobe, wait out read latency, complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_be_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          if (access_d) begin
            wr_q       <= apb.pwrite;
            mem_addr_q <= word_addr_d;
            mem_be_q   <= apb.pwrite ? apb.pstrb : '1;
            mem_din_q  <= apb.pwdata;
            if (bad_d) begin
              // Refused transfer: no memory strobe, complete next cycle with error.
              state_q   <= S_DONE;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
            end else begin
              state_q  <= S_ISSUE;
              mem_wr_q <= apb.pwrite;
              mem_rd_q <= ~apb.pwrite;
            end
          end
        end

        S_ISSUE: begin
          mem_wr_q <= 1'b0;
          mem_rd_q <= 1'b0;
          if (wr_q) begin
            state_q  <= S_DONE;
            pready_q <= 1'b1;
          end else if (RD_LATENCY == 0) begin
            // Combinational memory: data is valid alongside the read strobe.
            prdata_q <= mem_data_out;
            state_q  <= S_DONE;
            pready_q <= 1'b1;
          end else begin
            cnt_q   <= CNT_W'(RD_LATENCY);
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            prdata_q <= mem_data_out;
            state_q  <= S_DONE;
            pready_q <= 1'b1;
          end
        end

        S_DONE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state_q   <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_completer.sv
// Bench for apb_mem_completer: APB requester driver, a RAM macro model with one
// cycle of read latency, and a word-array reference model of the decoded memory.
module tb_apb_mem_completer;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MEMB = 256;
  localparam int RDL  = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_wr, mem_rd;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_mem_completer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_mem_completer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(MEMB), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .apb(bus),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_be(mem_be), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // RAM macro model: byte-enabled write, registered read (one cycle latency).
  bit [31:0] ram [64];
  always @(posedge clk) begin : ram_model
    logic [31:0] w;
    w = ram[mem_address[5:0]];
    if (mem_wr) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) w[8*b +: 8] = mem_data_in[8*b +: 8];
      ram[mem_address[5:0]] <= w;
    end
    if (mem_rd) mem_data_out <= ram[mem_address[5:0]];
  end

  // Reference model of memory contents as seen through the APB port.
  bit [31:0] ref_mem [64];

  function automatic bit ref_bad(input bit wr, input logic [31:0] a, input logic [3:0] s);
    return (a >= MEMB) || (wr && (s == 4'h0));
  endfunction

  function automatic int ref_lat(input bit wr, input logic [31:0] a, input logic [3:0] s);
    if (ref_bad(wr, a, s)) return 1;
    return wr ? 2 : 2 + RDL;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (ref_bad(1'b1, a, s)) return;
    idx = int'(a / 4);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (a >= MEMB) return 32'h0;
    return ref_mem[int'(a / 4)];
  endfunction

  // Protocol monitor: pready is a single-cycle pulse, prdata is quiet outside pready,
  // and the two memory strobes are never asserted together.
  int   pready_cnt  = 0;
  int   viol_cnt    = 0;
  logic pready_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.pready === 1'b1) pready_cnt <= pready_cnt + 1;
      if (mem_wr === 1'b1 && mem_rd === 1'b1) viol_cnt <= viol_cnt + 1;
      if (bus.pready !== 1'b1 && bus.prdata !== 32'h0) viol_cnt <= viol_cnt + 1;
      if (bus.pready === 1'b1 && pready_prev === 1'b1) viol_cnt <= viol_cnt + 1;
    end
    pready_prev <= bus.pready;
  end

  // Observations of the last transfer.
  logic [31:0] obs_rdata, obs_addr, obs_din;
  logic        obs_err;
  logic [3:0]  obs_be;
  int          obs_lat, obs_scyc, obs_nwr, obs_nrd;

  task automatic drive_idle();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
  endtask

  // One APB transfer; entered and left #1 after a rising edge. Cycle 0 is the
  // first access-phase cycle; obs_lat is the cycle index of pready (-1 if none).
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb);
    bit done;
    done = 1'b0;
    obs_nwr = 0; obs_nrd = 0; obs_scyc = -1; obs_lat = -1;
    obs_rdata = '0; obs_err = 1'b0; obs_addr = '0; obs_be = '0; obs_din = '0;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wdata; bus.pstrb = strb;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk);
      if (mem_wr === 1'b1) obs_nwr++;
      if (mem_rd === 1'b1) obs_nrd++;
      if (mem_wr === 1'b1 || mem_rd === 1'b1) begin
        obs_scyc = c; obs_addr = mem_address; obs_be = mem_be; obs_din = mem_data_in;
      end
      if (bus.pready === 1'b1) begin
        done = 1'b1; obs_lat = c; obs_rdata = bus.prdata; obs_err = bus.pslverr;
      end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.pready !== 1'b0 || bus.pslverr !== 1'b0) begin errors++;
      $display("FAIL reset_apb: pready=%b pslverr=%b want 0 0", bus.pready, bus.pslverr); end
    checks++; if (bus.prdata !== 32'h0) begin errors++;
      $display("FAIL reset_prdata: got %h want 0", bus.prdata); end
    checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || mem_be !== 4'h0) begin errors++;
      $display("FAIL reset_strobes: wr=%b rd=%b be=%h want 0 0 0", mem_wr, mem_rd, mem_be); end
    checks++; if (mem_address !== 32'h0 || mem_data_in !== 32'h0) begin errors++;
      $display("FAIL reset_mem_bus: addr=%h din=%h want 0 0", mem_address, mem_data_in); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    apb_xfer(1'b1, 32'hF0, 32'h000A3210, 4'hF);
    ref_write(32'hF0, 32'h000A3210, 4'hF);
    checks++; if (obs_nwr !== 1 || obs_nrd !== 0 || obs_scyc !== 1) begin errors++;
      $display("FAIL wr_strobe: nwr=%0d nrd=%0d cyc=%0d want 1 0 1", obs_nwr, obs_nrd, obs_scyc); end
    checks++; if (obs_addr !== 32'h3C || obs_be !== 4'hF || obs_din !== 32'h000A3210) begin errors++;
      $display("FAIL wr_mem_bus: addr=%h be=%h din=%h want 3c f 000a3210", obs_addr, obs_be, obs_din); end
    checks++; if (obs_lat !== 2 || obs_err !== 1'b0) begin errors++;
      $display("FAIL wr_ready: lat=%0d err=%b want 2 0", obs_lat, obs_err); end
    apb_xfer(1'b0, 32'hF0, 32'h0, 4'h0);
    checks++; if (obs_nrd !== 1 || obs_nwr !== 0 || obs_scyc !== 1 || obs_be !== 4'hF) begin errors++;
      $display("FAIL rd_strobe: nrd=%0d nwr=%0d cyc=%0d be=%h want 1 0 1 f", obs_nrd, obs_nwr, obs_scyc, obs_be); end
    checks++; if (obs_lat !== 2 + RDL || obs_err !== 1'b0) begin errors++;
      $display("FAIL rd_ready: lat=%0d err=%b want %0d 0", obs_lat, obs_err, 2 + RDL); end
    checks++; if (obs_rdata !== ref_read(32'hF0)) begin errors++;
      $display("FAIL rd_data: got %h want %h", obs_rdata, ref_read(32'hF0)); end
  endtask

  task automatic test_byte_write();
    apb_xfer(1'b1, 32'h3C, 32'h11223344, 4'hF);
    ref_write(32'h3C, 32'h11223344, 4'hF);
    apb_xfer(1'b1, 32'h3D, 32'h00001000, 4'b0010);
    ref_write(32'h3D, 32'h00001000, 4'b0010);
    checks++; if (obs_be !== 4'b0010 || obs_addr !== 32'h0F || obs_nwr !== 1) begin errors++;
      $display("FAIL byte_wr_bus: be=%b addr=%h nwr=%0d want 0010 0f 1", obs_be, obs_addr, obs_nwr); end
    apb_xfer(1'b0, 32'h3C, 32'h0, 4'h0);
    checks++; if (obs_rdata !== ref_read(32'h3C)) begin errors++;
      $display("FAIL byte_rd_data: got %h want %h", obs_rdata, ref_read(32'h3C)); end
  endtask

  task automatic test_errors();
    apb_xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    checks++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_nwr !== 0 || obs_rdata !== 32'h0) begin errors++;
      $display("FAIL err_wr: lat=%0d err=%b nwr=%0d rdata=%h want 1 1 0 0", obs_lat, obs_err, obs_nwr, obs_rdata); end
    apb_xfer(1'b0, 32'h400, 32'h0, 4'h0);
    checks++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_nrd !== 0 || obs_rdata !== 32'h0) begin errors++;
      $display("FAIL err_rd: lat=%0d err=%b nrd=%0d rdata=%h want 1 1 0 0", obs_lat, obs_err, obs_nrd, obs_rdata); end
    apb_xfer(1'b1, 32'hF0, 32'hFFFFFFFF, 4'h0);
    checks++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_nwr !== 0) begin errors++;
      $display("FAIL err_nostrb: lat=%0d err=%b nwr=%0d want 1 1 0", obs_lat, obs_err, obs_nwr); end
    apb_xfer(1'b0, 32'hF0, 32'h0, 4'h0);
    checks++; if (obs_rdata !== ref_read(32'hF0) || obs_err !== 1'b0) begin errors++;
      $display("FAIL err_nostrb_rb: got %h err=%b want %h 0", obs_rdata, obs_err, ref_read(32'hF0)); end
  endtask

  task automatic test_back_to_back();
    int start_cnt;
    logic [31:0] a, d;
    start_cnt = pready_cnt;
    for (int i = 0; i < 8; i++) begin
      a = 32'hB0 + 32'(4 * i);
      d = 32'hC0D942F0 + 32'(i);
      apb_xfer(1'b1, a, d, 4'hF);
      ref_write(a, d, 4'hF);
      checks++; if (obs_lat !== 2 || obs_nwr !== 1) begin errors++;
        $display("FAIL b2b_wr[%0d]: lat=%0d nwr=%0d want 2 1", i, obs_lat, obs_nwr); end
    end
    for (int i = 0; i < 8; i++) begin
      a = 32'hB0 + 32'(4 * i);
      apb_xfer(1'b0, a, 32'h0, 4'h0);
      checks++; if (obs_lat !== 2 + RDL || obs_rdata !== ref_read(a)) begin errors++;
        $display("FAIL b2b_rd[%0d]: lat=%0d data=%h want %0d %h", i, obs_lat, obs_rdata, 2 + RDL, ref_read(a)); end
    end
    checks++; if (pready_cnt - start_cnt !== 16) begin errors++;
      $display("FAIL b2b_acks: got %0d want 16", pready_cnt - start_cnt); end
  endtask

  task automatic test_psel_drop();
    logic [31:0] d;
    d = $urandom;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h44; bus.pwdata = d; bus.pstrb = 4'hF;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    checks++; if (mem_wr !== 1'b1) begin errors++;
      $display("FAIL drop_wr_commit: mem_wr=%b want 1", mem_wr); end
    @(negedge clk);
    checks++; if (bus.pready !== 1'b0) begin errors++;
      $display("FAIL drop_ready_gated: pready=%b want 0", bus.pready); end
    @(posedge clk); #1;
    ref_write(32'h44, d, 4'hF);
    apb_xfer(1'b0, 32'h44, 32'h0, 4'h0);
    checks++; if (obs_rdata !== ref_read(32'h44) || obs_lat !== 2 + RDL) begin errors++;
      $display("FAIL drop_readback: data=%h lat=%0d want %h %0d", obs_rdata, obs_lat, ref_read(32'h44), 2 + RDL); end
  endtask

  task automatic test_reset_mid();
    int start_cnt;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 32'hF0; bus.pwdata = '0; bus.pstrb = '0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_rd !== 1'b1) begin errors++;
      $display("FAIL rstmid_issue: mem_rd=%b want 1", mem_rd); end
    @(negedge clk);
    start_cnt = pready_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.pready !== 1'b0 || bus.pslverr !== 1'b0 || bus.prdata !== 32'h0) begin errors++;
      $display("FAIL rstmid_apb: pready=%b pslverr=%b prdata=%h want 0 0 0", bus.pready, bus.pslverr, bus.prdata); end
    checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || mem_be !== 4'h0 ||
                  mem_address !== 32'h0 || mem_data_in !== 32'h0) begin errors++;
      $display("FAIL rstmid_mem: wr=%b rd=%b be=%h addr=%h din=%h want all 0",
               mem_wr, mem_rd, mem_be, mem_address, mem_data_in); end
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pready_cnt !== start_cnt) begin errors++;
      $display("FAIL rstmid_no_ack: acks=%0d want 0", pready_cnt - start_cnt); end
    apb_xfer(1'b0, 32'hF0, 32'h0, 4'h0);
    checks++; if (obs_lat !== 2 + RDL || obs_rdata !== ref_read(32'hF0) || obs_err !== 1'b0) begin errors++;
      $display("FAIL rstmid_fresh_rd: lat=%0d data=%h err=%b want %0d %h 0",
               obs_lat, obs_rdata, obs_err, 2 + RDL, ref_read(32'hF0)); end
  endtask

  task automatic test_random();
    bit          wr, bad;
    logic [31:0] a, d;
    logic [3:0]  s;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 300));
      s  = 4'($urandom_range(0, 15));
      d  = $urandom;
      bad = ref_bad(wr, a, s);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      apb_xfer(wr, a, d, s);
      checks++; if (obs_lat !== ref_lat(wr, a, s) || obs_err !== bad) begin errors++;
        $display("FAIL rnd_ready[%0d] wr=%b a=%h s=%h: lat=%0d err=%b want %0d %b",
                 i, wr, a, s, obs_lat, obs_err, ref_lat(wr, a, s), bad); end
      checks++; if (obs_nwr + obs_nrd !== (bad ? 0 : 1)) begin errors++;
        $display("FAIL rnd_strobes[%0d]: got %0d want %0d", i, obs_nwr + obs_nrd, bad ? 0 : 1); end
      if (!bad) begin
        checks++; if (obs_addr !== (a >> 2) || obs_be !== (wr ? s : 4'hF)) begin errors++;
          $display("FAIL rnd_mem_bus[%0d]: addr=%h be=%h want %h %h", i, obs_addr, obs_be, a >> 2, wr ? s : 4'hF); end
      end
      if (wr) ref_write(a, d, s);
      else begin
        checks++; if (obs_rdata !== (bad ? 32'h0 : ref_read(a))) begin errors++;
          $display("FAIL rnd_rdata[%0d] a=%h: got %h want %h", i, a, obs_rdata, bad ? 32'h0 : ref_read(a)); end
      end
    end
  endtask

  task automatic test_protocol();
    checks++; if (viol_cnt !== 0) begin errors++;
      $display("FAIL protocol_monitor: violations=%0d want 0", viol_cnt); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    test_reset();
    test_write_read();
    test_byte_write();
    test_errors();
    test_back_to_back();
    test_psel_drop();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
